// File: rtl/labfinal_soc_rand_pkg.sv
// labfinal_soc_rand_pkg: register map, LFSR constants and the Galois step shared by the random generator.
package labfinal_soc_rand_pkg;
    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_SEED  = 2'd1,
        ADDR_CTRL  = 2'd2,
        ADDR_COUNT = 2'd3
    } addr_e;

    localparam logic [31:0] TAPS_DEFAULT   = 32'h8020_0003;
    localparam logic [31:0] SEED_DEFAULT_C = 32'h0000_0001;
    localparam logic [31:0] WEYL_INC       = 32'h9E37_79B9;

    function automatic logic [31:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        return (state >> 1) ^ (state[0] ? taps : 32'h0);
    endfunction
endpackage

// File: rtl/labfinal_soc_rand_lfsr.sv
// labfinal_soc_rand_lfsr: Galois LFSR state plus step counter; a load wins over a step and never stores zero.
module labfinal_soc_rand_lfsr
    import labfinal_soc_rand_pkg::*;
#(
    parameter logic [31:0] TAPS = TAPS_DEFAULT,
    parameter logic [31:0] SEED = SEED_DEFAULT_C
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state,
    output logic [31:0] count
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEED;
            count <= '0;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
            count <= '0;
        end else if (step) begin
            state <= lfsr_next(state, TAPS);
            count <= count + 32'd1;
        end
    end
endmodule

// File: rtl/labfinal_soc_rand_gen.sv
// labfinal_soc_rand_gen: Avalon-MM LFSR random generator (DATA/SEED/CTRL/COUNT).
// Define RAND_GEN_WHITEN_EN to XOR a Weyl sequence into DATA reads and rand_bit.
module labfinal_soc_rand_gen
    import labfinal_soc_rand_pkg::*;
#(
    parameter logic [31:0] TAPS         = TAPS_DEFAULT,
    parameter logic [31:0] SEED_DEFAULT = SEED_DEFAULT_C
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        rand_bit
);
    logic        rd, wr, step, load, ctrl_run;
    logic [31:0] lfsr, count, data_out;

    assign rd   = chipselect & ~read_n;
    assign wr   = chipselect & ~write_n;
    assign step = ctrl_run | (rd & (address == ADDR_DATA));
    assign load = wr & (address == ADDR_SEED);

    labfinal_soc_rand_lfsr #(.TAPS(TAPS), .SEED(SEED_DEFAULT)) u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .step     (step),
        .load     (load),
        .load_val (writedata),
        .state    (lfsr),
        .count    (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ctrl_run <= 1'b0;
        else if (wr && address == ADDR_CTRL)
            ctrl_run <= writedata[0];
    end

`ifdef RAND_GEN_WHITEN_EN
    logic [31:0] w;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            w <= '0;
        else if (load)
            w <= '0;
        else if (step)
            w <= w + WEYL_INC;
    end

    assign data_out = lfsr ^ w;
`else
    assign data_out = lfsr;
`endif

    assign rand_bit = data_out[0];

    // SEED reads expose the raw LFSR even when DATA is whitened.
    always_comb begin
        readdata = !chipselect              ? 32'h0 :
                   address == ADDR_DATA     ? data_out :
                   address == ADDR_SEED     ? lfsr :
                   address == ADDR_CTRL     ? {31'h0, ctrl_run} : count;
    end
endmodule
